// File: rtl/truth_table_sweeper_if.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper_if
//
// Groups the stimulus/capture signals between a truth_table_sweeper and
// whatever instantiates it. The sweeper drives vec, and the downstream
// combinational block answers on dut_out.
//
// Parameters:
//   N_IN            number of inputs driven on vec (1..6)
//
// Signals:
//   start           sweep request (master -> slave)
//   expected        expected output per combination, bit i for vec=i
//   dut_out         downstream block output (master -> slave)
//   abort           abandon a running sweep (only with SWEEP_ABORT_EN)
//   vec             stimulus to the downstream block (slave -> master)
//   busy            sweep in progress
//   done            one-cycle completion pulse
//   mask            captured outputs, bit i for vec=i
//   match           mask equals latched expected
//   mismatch_count  number of combinations that disagreed
//
// Modports:
//   master          the bench or the controller that requests sweeps
//   slave           the sweeper itself
//
// Build option: define SWEEP_ABORT_EN to add the abort signal.
// -----------------------------------------------------------------------------
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
);
  localparam int N_COMB = 1 << N_IN;

  logic                start;
  logic [N_COMB-1:0]   expected;
  logic                dut_out;
`ifdef SWEEP_ABORT_EN
  logic                abort;
`endif
  logic [N_IN-1:0]     vec;
  logic                busy;
  logic                done;
  logic [N_COMB-1:0]   mask;
  logic                match;
  logic [N_IN:0]       mismatch_count;

  modport master (
    output start, expected, dut_out,
`ifdef SWEEP_ABORT_EN
    output abort,
`endif
    input  vec, busy, done, mask, match, mismatch_count
  );

  modport slave (
    input  start, expected, dut_out,
`ifdef SWEEP_ABORT_EN
    input  abort,
`endif
    output vec, busy, done, mask, match, mismatch_count
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//
// Stimulus/capture stage for a combinational N_IN-input, single-output block.
// On start it walks vec through 0 .. 2**N_IN-1, holds each value for
// SETTLE_CYCLES cycles, samples dut_out into mask[vec], and at the end
// reports whether the captured truth table equals the expected one.
//
// Parameters:
//   N_IN            number of inputs driven on vec (1..6)
//   SETTLE_CYCLES   cycles vec is held before dut_out is sampled (>=1)
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   bus             truth_table_sweeper_if slave modport (see interface)
//
// Timing: each combination costs SETTLE_CYCLES+1 cycles, so done is high in
// the cycle after edge 2**N_IN*(SETTLE_CYCLES+1), counted from the edge that
// accepted start. busy is high in SETTLE and SAMPLE only.
//
// Build option: define SWEEP_ABORT_EN to honour bus.abort, which returns a
// running sweep to IDLE without a done pulse, keeping the partial mask and
// mismatch count.
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  truth_table_sweeper_if.slave bus
);

  localparam int N_COMB = 1 << N_IN;
  localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [N_IN-1:0]  VEC_LAST   = {N_IN{1'b1}};
  localparam logic [N_IN-1:0]  VEC_ONE    = N_IN'(1);
  localparam logic [N_IN:0]    MM_ONE     = (N_IN + 1)'(1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  settle_cnt;
  logic [N_COMB-1:0] exp_q;
  logic [N_IN-1:0]   vec_q;
  logic              busy_q;
  logic              done_q;
  logic [N_COMB-1:0] mask_q;
  logic              match_q;
  logic [N_IN:0]     mm_q;

  logic [N_COMB-1:0] mask_wr;
  logic              sample_miss;
  logic              abort_req;

  // Mask as it will look after the current sample is written; the final
  // compare uses this so match is already valid in the done cycle.
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    mask_wr        = mask_q;
    mask_wr[vec_q] = bus.dut_out;
    sample_miss    = (bus.dut_out != exp_q[vec_q]);
  end

`ifdef SWEEP_ABORT_EN
  // abort only matters while a sweep is running.
  assign abort_req = bus.abort && ((state == ST_SETTLE) || (state == ST_SAMPLE));
`else
  assign abort_req = 1'b0;
`endif

  // NOTE: all state in this block uses non-blocking assignments so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      exp_q      <= '0;
      vec_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mask_q     <= '0;
      match_q    <= 1'b0;
      mm_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            exp_q      <= bus.expected;
            mask_q     <= '0;
            mm_q       <= '0;
            match_q    <= 1'b0;
            vec_q      <= '0;
            settle_cnt <= CNT_RELOAD;
            busy_q     <= 1'b1;
            state      <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (abort_req) begin
            state   <= ST_IDLE;
            busy_q  <= 1'b0;
            vec_q   <= '0;
            match_q <= 1'b0;
          end else if (settle_cnt == '0) begin
            state <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - CNT_ONE;
          end
        end

        ST_SAMPLE: begin
          // An abort in the sample cycle wins, so this combination is not
          // recorded at all.
          if (abort_req) begin
            state   <= ST_IDLE;
            busy_q  <= 1'b0;
            vec_q   <= '0;
            match_q <= 1'b0;
          end else begin
            mask_q <= mask_wr;
            if (sample_miss) begin
              mm_q <= mm_q + MM_ONE;
            end
            if (vec_q == VEC_LAST) begin
              // vec stays at the last combination until the next start.
              state   <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              match_q <= (mask_wr == exp_q);
            end else begin
              vec_q      <= vec_q + VEC_ONE;
              settle_cnt <= CNT_RELOAD;
              state      <= ST_SETTLE;
            end
          end
        end

        ST_DONE: begin
          // start is not looked at here; a held start is taken in IDLE.
          match_q <= (mask_q == exp_q);
          state   <= ST_IDLE;
        end

        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vec            = vec_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.mask           = mask_q;
  assign bus.match          = match_q;
  assign bus.mismatch_count = mm_q;

endmodule
